cordic_result_collector: RTL and testbench

- Return-path counterpart of the adder's first stage: that stage converts two floats to CORDIC fixed point and issues them; this block collects the two CORDIC results and converts them back to IEEE-754 single.
- Accepts two independent result strobes and waits until both channels are captured.
- Normalises both magnitudes in parallel (sequential shifter), then emits both floats with a one-cycle done pulse to the final summing stage.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/fixed_to_float_unit.sv | 74 +++++++
 rtl/cordic_result_collector.sv | 112 +++++++++++
 tb/tb_cordic_result_collector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the float<->CORDIC adder path: widths, exponent bias,
// the collect/normalise/pack state encoding and a leading-zero helper.
package adder_pkg;

  localparam int FLT_DATA_WIDTH    = 32;
  localparam int CORDIC_DATA_WIDTH = 22;
  localparam int FRAC_BITS         = 20;
  localparam int FLT_EXP_BIAS      = 127;
  localparam int FLT_MAN_WIDTH     = 23;
  localparam int SHIFT_CNT_WIDTH   = 5;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_NORM    = 2'b01,
    ST_PACK    = 2'b11
  } state_e;

  // The issuing stage calls its idle state IDLE; it shares the COLLECT code.
  localparam state_e ST_IDLE = ST_COLLECT;

  // Leading-zero count of a CORDIC magnitude; returns 0 for a zero input.
  function automatic logic [SHIFT_CNT_WIDTH-1:0] lzc(
    input logic [CORDIC_DATA_WIDTH-1:0] v
  );
    lzc = '0;
    for (int i = 0; i < CORDIC_DATA_WIDTH; i++) begin
      if (v[i]) lzc = SHIFT_CNT_WIDTH'(CORDIC_DATA_WIDTH - 1 - i);
    end
  endfunction

endpackage

// File: rtl/fixed_to_float_unit.sv
// One channel: Q2.20 two's complement -> sign/magnitude -> normalised -> IEEE single.
// CORDIC_RESULT_COLLECTOR_FAST_NORM_EN selects a one-edge barrel normaliser.
module fixed_to_float_unit #(
  parameter int FLT_DATA_WIDTH    = adder_pkg::FLT_DATA_WIDTH,
  parameter int CORDIC_DATA_WIDTH = adder_pkg::CORDIC_DATA_WIDTH,
  parameter int FRAC_BITS         = adder_pkg::FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic                         step_i,
  input  logic [CORDIC_DATA_WIDTH-1:0] data_i,
  output logic                         finished_o,
  output logic [FLT_DATA_WIDTH-1:0]    float_o
);
  import adder_pkg::*;

  localparam int W       = CORDIC_DATA_WIDTH;
  localparam int EXP_TOP = FLT_EXP_BIAS + (W - 1 - FRAC_BITS);

  logic                       sign_q, sign_d;
  logic [W-1:0]               mag_q, mag_d;
  logic [SHIFT_CNT_WIDTH-1:0] k_q, k_d;
  logic [7:0]                 exp_w;
  logic                       is_norm;

  assign is_norm = (mag_q == '0) || mag_q[W-1];

  always_comb begin
    // NOTE: every comb output gets its hold value first so no path infers a latch.
    sign_d = sign_q;
    mag_d  = mag_q;
    k_d    = k_q;
    if (load_i) begin
      sign_d = data_i[W-1];
      mag_d  = data_i[W-1] ? -data_i : data_i;
      k_d    = '0;
`ifdef CORDIC_RESULT_COLLECTOR_FAST_NORM_EN
    end else if (step_i) begin
      mag_d = mag_q << lzc(mag_q);
      k_d   = lzc(mag_q);
`else
    end else if (step_i && !is_norm) begin
      mag_d = mag_q << 1;
      k_d   = k_q + SHIFT_CNT_WIDTH'(1);
`endif
    end
  end

`ifdef CORDIC_RESULT_COLLECTOR_FAST_NORM_EN
  assign finished_o = 1'b1;
`else
  assign finished_o = is_norm;
`endif

  assign exp_w   = 8'(EXP_TOP) - 8'(k_q);
  assign float_o = (mag_q == '0) ? '0
                 : {sign_q, exp_w, mag_q[W-2:0], {(FLT_MAN_WIDTH - (W - 1)){1'b0}}};

  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset too, so a conversion aborted by reset leaves no residue.
    if (!rst) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      k_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments only.
      sign_q <= sign_d;
      mag_q  <= mag_d;
      k_q    <= k_d;
    end
  end

endmodule

// File: rtl/cordic_result_collector.sv
// Collects two CORDIC results, normalises both in parallel and emits two floats
// with a done pulse. CORDIC_RESULT_COLLECTOR_FAST_NORM_EN: single-edge normalise.
module cordic_result_collector #(
  parameter int FLT_DATA_WIDTH    = adder_pkg::FLT_DATA_WIDTH,
  parameter int CORDIC_DATA_WIDTH = adder_pkg::CORDIC_DATA_WIDTH,
  parameter int FRAC_BITS         = adder_pkg::FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         in_valid_one,
  input  logic                         in_valid_two,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_one,
  input  logic [CORDIC_DATA_WIDTH-1:0] in_two,
  output logic                         busy,
  output logic                         done,
  output logic [FLT_DATA_WIDTH-1:0]    out_one,
  output logic [FLT_DATA_WIDTH-1:0]    out_two
);
  import adder_pkg::*;

  state_e                    state_q, state_d;
  logic                      cap_one_q, cap_one_d;
  logic                      cap_two_q, cap_two_d;
  logic                      done_q, busy_q;
  logic [FLT_DATA_WIDTH-1:0] out_one_q, out_two_q;
  logic                      load_one, load_two, step;
  logic                      fin_one, fin_two;
  logic [FLT_DATA_WIDTH-1:0] flt_one, flt_two;

  assign load_one = clk_en && (state_q == ST_COLLECT) && in_valid_one;
  assign load_two = clk_en && (state_q == ST_COLLECT) && in_valid_two;
  assign step     = clk_en && (state_q == ST_NORM);

  fixed_to_float_unit #(
    .FLT_DATA_WIDTH   (FLT_DATA_WIDTH),
    .CORDIC_DATA_WIDTH(CORDIC_DATA_WIDTH),
    .FRAC_BITS        (FRAC_BITS)
  ) u_unit_one (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_one),
    .step_i    (step),
    .data_i    (in_one),
    .finished_o(fin_one),
    .float_o   (flt_one)
  );

  fixed_to_float_unit #(
    .FLT_DATA_WIDTH   (FLT_DATA_WIDTH),
    .CORDIC_DATA_WIDTH(CORDIC_DATA_WIDTH),
    .FRAC_BITS        (FRAC_BITS)
  ) u_unit_two (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_two),
    .step_i    (step),
    .data_i    (in_two),
    .finished_o(fin_two),
    .float_o   (flt_two)
  );

  always_comb begin
    state_d   = state_q;
    cap_one_d = cap_one_q;
    cap_two_d = cap_two_q;
    case (state_q)
      ST_COLLECT: begin
        if (in_valid_one) cap_one_d = 1'b1;
        if (in_valid_two) cap_two_d = 1'b1;
        if (cap_one_d && cap_two_d) state_d = ST_NORM;
      end
      ST_NORM: begin
        if (fin_one && fin_two) state_d = ST_PACK;
      end
      ST_PACK: begin
        state_d   = ST_COLLECT;
        cap_one_d = 1'b0;
        cap_two_d = 1'b0;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cap_one_q <= 1'b0;
      cap_two_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      out_one_q <= '0;
      out_two_q <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cap_one_q <= cap_one_d;
      cap_two_q <= cap_two_d;
      done_q    <= (state_q == ST_PACK);
      busy_q    <= (state_d != ST_COLLECT);
      if (state_q == ST_PACK) begin
        out_one_q <= flt_one;
        out_two_q <= flt_two;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign out_one = out_one_q;
  assign out_two = out_two_q;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed-vector bench for cordic_result_collector; expected floats and
// latencies are hand-computed from the Q2.20 inputs.
module tb_cordic_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        in_valid_one;
  logic        in_valid_two;
  logic [21:0] in_one;
  logic [21:0] in_two;
  logic        busy;
  logic        done;
  logic [31:0] out_one;
  logic [31:0] out_two;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int done_seen;

  cordic_result_collector dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .in_valid_one(in_valid_one),
    .in_valid_two(in_valid_two),
    .in_one      (in_one),
    .in_two      (in_two),
    .busy        (busy),
    .done        (done),
    .out_one     (out_one),
    .out_two     (out_two)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and outputs change/are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int k);
`ifdef CORDIC_RESULT_COLLECTOR_FAST_NORM_EN
    return 2;
`else
    return 2 + k;
`endif
  endfunction

  task automatic strobe(input logic v1, input logic v2,
                        input logic [21:0] d1, input logic [21:0] d2);
    in_valid_one = v1;
    in_valid_two = v2;
    in_one       = d1;
    in_two       = d2;
    tick();
    in_valid_one = 1'b0;
    in_valid_two = 1'b0;
  endtask

  // Edges until done is seen, bounded at 60.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0;
    in_valid_one = 1'b0; in_valid_two = 1'b0;
    in_one = '0; in_two = '0;

    // Reset acts even with clk_en low.
    tick(); tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_one", out_one, 32'h0);
    check("rst_out_two", out_two, 32'h0);
    rst = 1'b1; clk_en = 1'b1;
    tick();

    // 1.0 and -1.0 together, k=1.
    strobe(1'b1, 1'b1, 22'h100000, 22'h300000);
    check("pm1_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("pm1_lat", 32'(lat), 32'(exp_lat(1)));
    check("pm1_one", out_one, 32'h3F800000);
    check("pm1_two", out_two, 32'hBF800000);

    // Back-to-back: strobe on the edge right after PACK; -2.0 has k=0.
    strobe(1'b1, 1'b1, 22'h100000, 22'h200000);
    check("b2b_done_pulse", 32'(done), 32'd0);
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'(exp_lat(1)));
    check("b2b_one", out_one, 32'h3F800000);
    check("b2b_two", out_two, 32'hC0000000);
    tick();
    check("b2b_done_fall", 32'(done), 32'd0);

    // Staggered strobes, stray third strobe during NORM.
    strobe(1'b1, 1'b0, 22'h080000, 22'h0);
    for (int i = 0; i < 4; i++) tick();
    check("stag_wait_busy", 32'(busy), 32'd0);
    strobe(1'b0, 1'b1, 22'h0, 22'h0C0000);
    strobe(1'b1, 1'b0, 22'h100000, 22'h0);
    wait_done(lat);
    check("stag_lat", 32'(lat + 1), 32'(exp_lat(2)));
    check("stag_one", out_one, 32'h3F000000);
    check("stag_two", out_two, 32'h3F400000);
    for (int i = 0; i < 3; i++) tick();
    check("stray_not_queued", 32'(busy), 32'd0);

    // Last strobe on a captured channel wins.
    strobe(1'b1, 1'b0, 22'h100000, 22'h0);
    strobe(1'b1, 1'b0, 22'h080000, 22'h0);
    strobe(1'b0, 1'b1, 22'h0, 22'h100000);
    wait_done(lat);
    check("lastwin_one", out_one, 32'h3F000000);
    check("lastwin_two", out_two, 32'h3F800000);

    // Boundaries: -2.0 (k=0) and 2^-20 (k=21, worst case).
    strobe(1'b1, 1'b1, 22'h200000, 22'h000001);
    wait_done(lat);
    check("bnd_lat", 32'(lat), 32'(exp_lat(21)));
    check("bnd_one", out_one, 32'hC0000000);
    check("bnd_two", out_two, 32'h35800000);

    // Zero inputs.
    strobe(1'b1, 1'b1, 22'h0, 22'h0);
    wait_done(lat);
    check("zero_lat", 32'(lat), 32'(exp_lat(0)));
    check("zero_one", out_one, 32'h0);
    check("zero_two", out_two, 32'h0);

    // clk_en low for 4 cycles during NORM stretches latency by 4.
    strobe(1'b1, 1'b1, 22'h0C0000, 22'h380000);
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("gate_busy_hold", 32'(busy), 32'd1);
    clk_en = 1'b1;
    wait_done(lat);
    check("gate_lat", 32'(lat + 5), 32'(exp_lat(2) + 4));
    check("gate_one", out_one, 32'h3F400000);
    check("gate_two", out_two, 32'hBF000000);

    // Done holds while clk_en is low.
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_one", out_one, 32'h3F400000);
    clk_en = 1'b1;
    tick();
    check("hold_done_fall", 32'(done), 32'd0);

    // Reset mid-NORM discards the conversion.
    strobe(1'b1, 1'b1, 22'h000001, 22'h100000);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_one", out_one, 32'h0);
    check("abort_out_two", out_two, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_out_stay", out_one | out_two, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
